cround_sat: RTL
===============

Name: cround_sat

Overview:
- Requantizer for complex butterfly outputs: the narrowing counterpart of the widening complex adder stage.
- Takes an ADD_WIDTH complex sample (pr/pi) and arithmetic-shifts right by SHIFT with round-half-up. It then saturates to TOTAL_WIDTH so the result can feed the next QFT stage.
- Elastic 2-stage pipeline with valid/ready backpressure. Sits between each cadd/cmul stage output and the next stage input.

Parameters:
- IN_W, `ADD_WIDTH (17 at default fixed-point config), input component width, two's complement.
- OUT_W, `TOTAL_WIDTH (16), output component width.
- SHIFT, 1, right-shift amount (scaling by 2^-SHIFT); 0 allowed (pure saturation, no rounding add).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept input this cycle.
- in_re  in  IN_W  real component, signed.
- in_im  in  IN_W  imaginary component, signed.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_re  out  OUT_W  requantized real, signed.
- out_im  out  OUT_W  requantized imaginary, signed.
- out_sat  out  1  either component of current output was clipped.
- sat_clr  in  1  synchronous clear of saturation statistics.
- sat_count  out  16  saturated-beat counter (optional feature).

Behaviour:
- Reset (async, rst=1): all valid flags, out_re, out_im, out_sat and sat_count go to 0. Any in-flight samples are discarded, with no output beat. in_ready=1 during reset.
- Transfer rules: input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
- Stage 1 (S1) computes r = in + 2^(SHIFT-1), with the add omitted when SHIFT=0.
  - Width is IN_W+1, so no internal overflow.
  - S1 registers r and s1_valid.
- Stage 2 (S2, output register) computes q = r >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, output max; if q < -2^(OUT_W-1), output min; otherwise q[OUT_W-1:0].
  - out_sat = clip_re | clip_im.
- Advance rules:
  - S2 loads when !out_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || (!out_valid || out_ready), combinational from out_ready.
- Latency: 2 cycles from input handshake to out_valid, with no stall. Throughput: 1 beat/cycle with out_ready held high.
- Stall: when out_valid && !out_ready, out_re/out_im/out_sat hold stable and S1 holds. in_ready=0 once S1 is full. No beat is lost or duplicated.
- Simultaneous input and output handshakes in one cycle are legal; the pipeline shifts by one.
- Rounding is round-half-up toward +inf: -3 (SHIFT=1) -> -1, +3 -> 2, -1 -> 0.
- Real and imaginary lanes are independent except for the shared valid path and the ORed out_sat.

Optional Feature:
- Macro: CROUND_SAT_STATS_EN.
- Defined:
  - sat_count increments by 1 on each output handshake with out_sat=1 and saturates at 16'hFFFF (no wrap).
  - sat_clr=1 zeroes it next edge, with priority over increment.
- Undefined: sat_count is tied to 0 and sat_clr is ignored. The port list is unchanged.

Decomposition:
- fixed_point_params.vh holds TOTAL_WIDTH, ADD_WIDTH and a new QFT_STAGE_SHIFT default.
- Sub-module round_sat_lane(IN_W, OUT_W, SHIFT): combinational round-add and saturate, instantiated once per component.
- cround_sat owns all registers, the handshake and the counter.

Test Plan:
- Basic rounding (default params): in_re=3, in_im=-3 -> out_re=2, out_im=-1, out_sat=0, out_valid exactly 2 cycles after handshake.
- Saturation: in_re=65535, in_im=-65536 -> out_re=32767, out_im=-32768, out_sat=1. With the stats feature, sat_count=1 after the handshake.
- Backpressure: stream 0,2,4..20 with out_ready toggling 1010... and random in_valid gaps -> outputs 0,1,2..10 in order, none lost or duplicated, outputs stable while stalled.
- Full throughput: in_valid=1 and out_ready=1 for 8 beats -> 8 consecutive output beats; in_ready never drops.
- Reset mid-operation: assert rst with S1 and S2 full and out_ready=0 -> out_valid=0 immediately (async), sat_count=0. After release, the next sample emerges with latency 2 and no stale data appears.
- Counter limits (stats feature): force 65537 saturated beats -> sat_count=16'hFFFF. sat_clr concurrent with a saturated beat -> 0.

Source files
------------

// File: rtl/cround_sat_pkg.sv
// Shared fixed-point configuration for the complex requantizer (cround_sat).
// Holds the default component widths, the default per-stage shift and the statistics counter width.
package cround_sat_pkg;

    localparam int TOTAL_WIDTH     = 16;
    localparam int ADD_WIDTH       = 17;
    localparam int QFT_STAGE_SHIFT = 1;
    localparam int SAT_CNT_W       = 16;

endpackage

// File: rtl/round_sat_lane.sv
// One component lane of the requantizer: a round-half-up pre-add (stage 1 input side)
// and an arithmetic shift with saturation (stage 2 input side). Purely combinational.
module round_sat_lane
    import cround_sat_pkg::*;
#(
    parameter int IN_W  = ADD_WIDTH,
    parameter int OUT_W = TOTAL_WIDTH,
    parameter int SHIFT = QFT_STAGE_SHIFT
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [IN_W:0]    rnd,
    input  logic signed [IN_W:0]    r,
    output logic signed [OUT_W-1:0] q,
    output logic                    clip
);

    localparam int RW  = IN_W + 1;
    localparam int EW  = ((RW > OUT_W) ? RW : OUT_W) + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Half an output LSB; zero when there is no shift so nothing is rounded.
    localparam logic signed [RW-1:0] HALF = (SHIFT > 0) ? (RW'(1) <<< RSH) : '0;
    localparam logic signed [EW-1:0] MAXV = (EW'(1) <<< (OUT_W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] MINV = -(EW'(1) <<< (OUT_W - 1));

    function automatic logic signed [RW-1:0] round_add(input logic signed [IN_W-1:0] x);
        logic signed [RW-1:0] xe;
        xe = {x[IN_W-1], x};
        return xe + HALF;
    endfunction

    // Returns {clip, value}; compared in a width that holds both ranges.
    function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] x);
        logic signed [EW-1:0] xe;
        xe = {{(EW - RW){x[RW-1]}}, x};
        xe = xe >>> SHIFT;
        if (xe > MAXV) begin
            return {1'b1, MAXV[OUT_W-1:0]};
        end else if (xe < MINV) begin
            return {1'b1, MINV[OUT_W-1:0]};
        end
        return {1'b0, xe[OUT_W-1:0]};
    endfunction

    always_comb begin
        rnd       = round_add(din);
        {clip, q} = saturate(r);
    end

endmodule

// File: rtl/cround_sat.sv
// Complex requantizer: round-half-up, arithmetic right shift by SHIFT, saturate to OUT_W,
// in an elastic 2-stage valid/ready pipeline. Define CROUND_SAT_STATS_EN for the saturation counter.
module cround_sat
    import cround_sat_pkg::*;
#(
    parameter int IN_W  = ADD_WIDTH,
    parameter int OUT_W = TOTAL_WIDTH,
    parameter int SHIFT = QFT_STAGE_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_re,
    input  logic signed [IN_W-1:0]   in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic                     out_sat,
    input  logic                     sat_clr,
    output logic [SAT_CNT_W-1:0]     sat_count
);

    localparam int RW = IN_W + 1;

    logic                    vld_p1;
    logic signed [RW-1:0]    re_p1, im_p1;
    logic signed [RW-1:0]    re_rnd, im_rnd;
    logic signed [OUT_W-1:0] re_sat, im_sat;
    logic                    clip_re, clip_im;
    logic                    s1_load, s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !vld_p1 || s2_load;
    assign in_ready = s1_load;

    round_sat_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane_re (
        .din  (in_re),
        .rnd  (re_rnd),
        .r    (re_p1),
        .q    (re_sat),
        .clip (clip_re)
    );

    round_sat_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane_im (
        .din  (in_im),
        .rnd  (im_rnd),
        .r    (im_p1),
        .q    (im_sat),
        .clip (clip_im)
    );

    // ---- stage 1: rounded, widened sample ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_load) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            re_p1 <= re_rnd;
            im_p1 <= im_rnd;
        end
    end

    // ---- stage 2: shifted, saturated output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_re  <= re_sat;
                out_im  <= im_sat;
                out_sat <= clip_re | clip_im;
            end
        end
    end

`ifdef CROUND_SAT_STATS_EN
    localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`else
    assign sat_count = {SAT_CNT_W{sat_clr & 1'b0}};
`endif

endmodule
